memory_requester: RTL and testbench

- Initiator side of the word-memory interface; issues single read/write transactions to the 256x16 Memory block on behalf of the core.
- Accepts one request at a time from the core over a valid/ready handshake and drives the memory strobes, address and write data.
- Tracks the memory's one-cycle registered read latency, captures read data, and returns a response over a valid/ready handshake.
- Honours i_halt by freezing all state, because the memory's clock is gated off while halted.

---
 rtl/argon_pkg.sv | 15 +
 rtl/memory_requester.sv | 166 ++++++++++++++++
 tb/tb_memory_requester.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/argon_pkg.sv
// Shared constants and state encoding for the word-memory initiator.
package argon_pkg;

   localparam int ARGON_DATA_W    = 16;
   localparam int ARGON_ADDR_W    = 16;
   localparam int ARGON_MEM_WORDS = 256;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MEM_REQ  = 2'd1,
      MEM_WAIT = 2'd2,
      RESP     = 2'd3
   } mem_req_state_t;

endpackage

// File: rtl/memory_requester.sv
// Initiator for the 256x16 word memory: one request in flight, strobes the
// memory, waits out the registered read latency and hands back a response.
// The whole block freezes while i_halt is high because the memory clock is
// gated off during that time.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | ready for a core request
// MEM_REQ  | strobe (re or we) presented to memory for one cycle
// MEM_WAIT | memory is producing registered read data
// RESP     | response held for the core until i_rsp_ready
module memory_requester
   import argon_pkg::*;
#(
   parameter int DATA_W    = ARGON_DATA_W,
   parameter int ADDR_W    = ARGON_ADDR_W,
   parameter int MEM_WORDS = ARGON_MEM_WORDS
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_halt,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_we,
   input  logic [ADDR_W-1:0] i_req_address,
   input  logic [DATA_W-1:0] i_req_wdata,
   output logic              o_rsp_valid,
   input  logic              i_rsp_ready,
   output logic [DATA_W-1:0] o_rsp_rdata,
   output logic              o_rsp_write,
   output logic              o_rsp_error,
   output logic [ADDR_W-1:0] o_memory_address,
   output logic [DATA_W-1:0] o_memory_data,
   output logic              o_memory_re,
   output logic              o_memory_we,
   input  logic [DATA_W-1:0] i_memory_data
);

   mem_req_state_t state_q, state_n;

   logic              req_we_q,   req_we_n;
   logic [ADDR_W-1:0] mem_addr_n;
   logic [DATA_W-1:0] mem_data_n;
   logic              mem_re_n,   mem_we_n;
   logic              rsp_valid_n;
   logic [DATA_W-1:0] rsp_rdata_n;
   logic              rsp_write_n, rsp_error_n;

   logic [31:0] req_addr_ext;
   logic        addr_in_range;

   // Unsigned compare over the full address width so 0x0100 is rejected,
   // never aliased onto word 0.
   assign req_addr_ext  = 32'(i_req_address);
   assign addr_in_range = (req_addr_ext < 32'(MEM_WORDS));

   // Halt also blocks acceptance so the core never sees a lost handshake.
   assign o_req_ready = (state_q == IDLE) & ~i_halt;

   // State register; frozen while halted.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= IDLE;
      end else if (!i_halt) begin
         state_q <= state_n;
      end
   end

   // Registered outputs and latched request fields; frozen while halted.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         req_we_q         <= 1'b0;
         o_memory_address <= '0;
         o_memory_data    <= '0;
         o_memory_re      <= 1'b0;
         o_memory_we      <= 1'b0;
         o_rsp_valid      <= 1'b0;
         o_rsp_rdata      <= '0;
         o_rsp_write      <= 1'b0;
         o_rsp_error      <= 1'b0;
      end else if (!i_halt) begin
         req_we_q         <= req_we_n;
         o_memory_address <= mem_addr_n;
         o_memory_data    <= mem_data_n;
         o_memory_re      <= mem_re_n;
         o_memory_we      <= mem_we_n;
         o_rsp_valid      <= rsp_valid_n;
         o_rsp_rdata      <= rsp_rdata_n;
         o_rsp_write      <= rsp_write_n;
         o_rsp_error      <= rsp_error_n;
      end
   end

   // Next-state and next-output decode.
   always_comb begin
      state_n     = state_q;
      req_we_n    = req_we_q;
      mem_addr_n  = o_memory_address;
      mem_data_n  = o_memory_data;
      mem_re_n    = o_memory_re;
      mem_we_n    = o_memory_we;
      rsp_valid_n = o_rsp_valid;
      rsp_rdata_n = o_rsp_rdata;
      rsp_write_n = o_rsp_write;
      rsp_error_n = o_rsp_error;

      unique case (state_q)
         IDLE: begin
            if (i_req_valid) begin
               req_we_n = i_req_we;
               if (addr_in_range) begin
                  mem_addr_n = i_req_address;
                  if (i_req_we) begin
                     mem_we_n   = 1'b1;
                     mem_data_n = i_req_wdata;
                  end else begin
                     mem_re_n   = 1'b1;
                  end
                  state_n = MEM_REQ;
               end else begin
                  // Out-of-range: memory is left untouched.
                  rsp_error_n = 1'b1;
                  rsp_rdata_n = '0;
                  rsp_write_n = i_req_we;
                  state_n     = RESP;
               end
            end
         end

         MEM_REQ: begin
            mem_re_n = 1'b0;
            mem_we_n = 1'b0;
            if (req_we_q) begin
               rsp_write_n = 1'b1;
               rsp_error_n = 1'b0;
               state_n     = RESP;
            end else begin
               state_n     = MEM_WAIT;
            end
         end

         MEM_WAIT: begin
            rsp_rdata_n = i_memory_data;
            state_n     = RESP;
         end

         RESP: begin
            // Valid rises one cycle after entry; consumption needs valid seen.
            if (o_rsp_valid && i_rsp_ready) begin
               rsp_valid_n = 1'b0;
               rsp_rdata_n = '0;
               rsp_write_n = 1'b0;
               rsp_error_n = 1'b0;
               state_n     = IDLE;
            end else begin
               rsp_valid_n = 1'b1;
            end
         end

         default: begin
            state_n = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_memory_requester.sv
// Directed bench for memory_requester with a behavioural 256x16 memory.
module tb_memory_requester;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        halt = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [15:0] req_address = '0;
   logic [15:0] req_wdata = '0;
   logic        rsp_ready = 1'b0;

   logic        req_ready;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic        rsp_write;
   logic        rsp_error;
   logic [15:0] mem_addr;
   logic [15:0] mem_data;
   logic        mem_re;
   logic        mem_we;
   logic [15:0] mem_rdata = '0;

   logic [15:0] mem [0:255];

   int checks = 0;
   int errors = 0;
   int re_cnt = 0;
   int we_cnt = 0;
   int overlap = 0;
   int wide = 0;
   logic prev_re = 1'b0;
   logic prev_we = 1'b0;
   int lat;

   memory_requester dut (
      .i_clk            (clk),
      .i_reset          (rst),
      .i_halt           (halt),
      .i_req_valid      (req_valid),
      .o_req_ready      (req_ready),
      .i_req_we         (req_we),
      .i_req_address    (req_address),
      .i_req_wdata      (req_wdata),
      .o_rsp_valid      (rsp_valid),
      .i_rsp_ready      (rsp_ready),
      .o_rsp_rdata      (rsp_rdata),
      .o_rsp_write      (rsp_write),
      .o_rsp_error      (rsp_error),
      .o_memory_address (mem_addr),
      .o_memory_data    (mem_data),
      .o_memory_re      (mem_re),
      .o_memory_we      (mem_we),
      .i_memory_data    (mem_rdata)
   );

   always #5 clk = ~clk;

   // Memory model: registered read, clock stopped while halted.
   always @(posedge clk) begin
      if (!halt) begin
         if (mem_we) mem[mem_addr[7:0]] <= mem_data;
         if (mem_re) mem_rdata <= mem[mem_addr[7:0]];
      end
   end

   // Strobe monitor: overlap, pulse width and pulse count.
   always @(negedge clk) begin
      if (!halt && !rst) begin
         if (mem_re && mem_we) overlap++;
         if (mem_re) re_cnt++;
         if (mem_we) we_cnt++;
         if (mem_re && prev_re) wide++;
         if (mem_we && prev_we) wide++;
         prev_re = mem_re;
         prev_we = mem_we;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!req_ready && n < 20) begin
         tick();
         n++;
      end
      chk(tag, {31'd0, req_ready}, 32'd1);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'(16'h1000 + i);

      // Reset
      tick();
      tick();
      chk("rst_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_strobes", {30'd0, mem_re, mem_we}, 32'd0);
      chk("rst_addr", {16'd0, mem_addr}, 32'd0);
      rst = 1'b0;
      tick();

      // Write 0x00A5 <- 0xBEEF
      req_valid = 1'b1; req_we = 1'b1; req_address = 16'h00A5; req_wdata = 16'hBEEF;
      tick();
      req_valid = 1'b0; req_address = 16'h0077; req_wdata = 16'h1234;
      chk("wr_we", {30'd0, mem_we, mem_re}, 32'd2);
      chk("wr_addr", {16'd0, mem_addr}, 32'h00A5);
      chk("wr_data", {16'd0, mem_data}, 32'hBEEF);
      chk("wr_ready_busy", {31'd0, req_ready}, 32'd0);
      tick();
      chk("wr_e1", {30'd0, mem_we, rsp_valid}, 32'd0);
      tick();
      chk("wr_e2_valid", {31'd0, rsp_valid}, 32'd1);
      chk("wr_e2_flags", {30'd0, rsp_write, rsp_error}, 32'd2);
      chk("wr_e2_rdata", {16'd0, rsp_rdata}, 32'd0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("wr_consumed", {30'd0, rsp_valid, req_ready}, 32'd1);

      // Read 0x00A5
      req_valid = 1'b1; req_we = 1'b0; req_address = 16'h00A5;
      tick();
      req_valid = 1'b0;
      chk("rd_re", {30'd0, mem_we, mem_re}, 32'd1);
      tick();
      chk("rd_e1", {30'd0, mem_re, rsp_valid}, 32'd0);
      tick();
      chk("rd_e2_valid", {31'd0, rsp_valid}, 32'd0);
      tick();
      chk("rd_e3_valid", {31'd0, rsp_valid}, 32'd1);
      chk("rd_e3_rdata", {16'd0, rsp_rdata}, 32'hBEEF);
      chk("rd_e3_flags", {30'd0, rsp_write, rsp_error}, 32'd0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      // Out-of-range read 0x0100
      req_valid = 1'b1; req_we = 1'b0; req_address = 16'h0100;
      tick();
      req_valid = 1'b0;
      chk("err_nostrobe", {30'd0, mem_re, mem_we}, 32'd0);
      chk("err_e0_valid", {31'd0, rsp_valid}, 32'd0);
      tick();
      chk("err_e1_valid", {31'd0, rsp_valid}, 32'd1);
      chk("err_flags", {30'd0, rsp_write, rsp_error}, 32'd1);
      chk("err_rdata", {16'd0, rsp_rdata}, 32'd0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      // Out-of-range write 0xFFFF
      req_valid = 1'b1; req_we = 1'b1; req_address = 16'hFFFF; req_wdata = 16'h5555;
      tick();
      req_valid = 1'b0;
      tick();
      chk("errw_flags", {29'd0, rsp_valid, rsp_write, rsp_error}, 32'd7);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("strobe_cnt_a", {re_cnt[15:0], we_cnt[15:0]}, {16'd1, 16'd1});

      // Read 0x0010 with consumer stall
      req_valid = 1'b1; req_we = 1'b0; req_address = 16'h0010;
      tick();
      req_valid = 1'b0;
      tick(); tick(); tick();
      for (int i = 0; i < 5; i++) begin
         chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
         chk("stall_rdata", {16'd0, rsp_rdata}, 32'h1010);
         chk("stall_ready", {31'd0, req_ready}, 32'd0);
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("stall_done", {30'd0, rsp_valid, req_ready}, 32'd1);

      // Read 0x0020 with a 3-cycle halt in MEM_WAIT, then halt in RESP
      req_valid = 1'b1; req_we = 1'b0; req_address = 16'h0020;
      tick();
      req_valid = 1'b0;
      tick();
      halt = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("halt_frozen", {14'd0, rsp_valid, req_ready, rsp_rdata}, 32'd0);
      end
      halt = 1'b0;
      tick();
      chk("halt_capture", {15'd0, rsp_valid, rsp_rdata}, 32'h1020);
      tick();
      chk("halt_valid", {15'd0, rsp_valid, rsp_rdata}, 32'h11020);
      halt = 1'b1; rsp_ready = 1'b1;
      tick();
      chk("halt_rsp_hold", {31'd0, rsp_valid}, 32'd1);
      halt = 1'b0;
      tick();
      rsp_ready = 1'b0;
      chk("halt_consumed", {30'd0, rsp_valid, req_ready}, 32'd1);

      // Asynchronous reset during MEM_REQ
      req_valid = 1'b1; req_we = 1'b0; req_address = 16'h0030;
      tick();
      req_valid = 1'b0;
      chk("arst_pre_re", {31'd0, mem_re}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("arst_outputs", {mem_addr, 12'd0, mem_re, mem_we, rsp_valid, req_ready}, 32'd1);
      tick();
      rst = 1'b0;
      tick(); tick(); tick();
      chk("arst_no_rsp", {30'd0, rsp_valid, req_ready}, 32'd1);
      req_valid = 1'b1; req_we = 1'b0; req_address = 16'h0001;
      tick();
      req_valid = 1'b0;
      tick(); tick(); tick();
      chk("arst_next_rd", {15'd0, rsp_valid, rsp_rdata}, 32'h11001);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      // Back-to-back reads 0x0000..0x0003
      req_valid = 1'b1; req_we = 1'b0; rsp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         req_address = 16'(k);
         wait_ready("b2b_ready");
         tick();
         lat = 0;
         while (!rsp_valid && lat < 20) begin
            tick();
            lat++;
         end
         chk("b2b_latency", lat, 32'd3);
         chk("b2b_rdata", {16'd0, rsp_rdata}, 32'(16'h1000 + k));
      end
      tick();
      req_valid = 1'b0; rsp_ready = 1'b0;
      chk("b2b_done", {31'd0, rsp_valid}, 32'd0);
      tick();

      chk("strobe_overlap", overlap, 32'd0);
      chk("strobe_wide", wide, 32'd0);
      chk("strobe_cnt_b", {re_cnt[15:0], we_cnt[15:0]}, {16'd8, 16'd1});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
